// File: rtl/delay_sweep_pkg.sv
// Shared types and default widths for the delay sweep controller.
package delay_sweep_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int NW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus registered rising-edge detector for the SYNC level.
// sedge is a one-cycle pulse asserted on the third clk edge after sync rises.
module sync_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic sync,
    output logic sedge
);

    logic sync_m;
    logic sync_s;
    logic sync_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_m <= 1'b0;
            sync_s <= 1'b0;
            sync_d <= 1'b0;
            sedge  <= 1'b0;
        end else begin
            sync_m <= sync;
            sync_s <= sync_m;
            sync_d <= sync_s;
            sedge  <= sync_s & ~sync_d;
        end
    end

endmodule

// File: rtl/delay_sweep_ctrl.sv
// Steps a delay word from del_start towards del_stop, holding each point for navg
// SYNC periods. Define DELAY_SWEEP_LOOP_EN to add the free-running 'loop' input.
module delay_sweep_ctrl
    import delay_sweep_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int NW = NW_DEFAULT
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic          sync,
`ifdef DELAY_SWEEP_LOOP_EN
    input  logic          loop,
`endif
    input  logic [DW-1:0] del_start,
    input  logic [DW-1:0] del_step,
    input  logic [DW-1:0] del_stop,
    input  logic [NW-1:0] navg,
    output logic [DW-1:0] del_out,
    output logic          upd,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] pt_idx,
    output sweep_state_t  state_dbg
);

    // start/abort are single-cycle request strobes accepted without a ready;
    // upd/done are single-cycle status strobes with no backpressure.
    sweep_state_t  state_q, state_d;
    logic [DW-1:0] del_q, del_d;
    logic [DW-1:0] idx_q, idx_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] stop_q, stop_d;
    logic [NW-1:0] navg_q, navg_d;
    logic          upd_q, upd_d;
    logic          done_q, done_d;
    logic [DW:0]   next_del;
    logic [NW-1:0] navg_eff;
    logic          last_pt;
    logic          sedge;
`ifdef DELAY_SWEEP_LOOP_EN
    logic [DW-1:0] base_q, base_d;
    logic          loop_q, loop_d;
`endif

    sync_edge_det u_sync (
        .clk    (clk),
        .resetn (resetn),
        .sync   (sync),
        .sedge  (sedge)
    );

    assign navg_eff = (navg_q == '0) ? NW'(1) : navg_q;
    assign next_del = {1'b0, del_q} + {1'b0, step_q};
    // Zero step or a carry would never reach del_stop, so both end the sweep.
    assign last_pt  = (step_q == '0) || next_del[DW] || (next_del[DW-1:0] > stop_q);

    always_comb begin
        state_d = state_q;
        del_d   = del_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        stop_d  = stop_q;
        navg_d  = navg_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
`ifdef DELAY_SWEEP_LOOP_EN
        base_d  = base_q;
        loop_d  = loop_q;
`endif
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        step_d  = del_step;
                        stop_d  = del_stop;
                        navg_d  = navg;
                        del_d   = del_start;
                        idx_d   = '0;
                        cnt_d   = '0;
                        upd_d   = 1'b1;
                        state_d = ST_ARM;
`ifdef DELAY_SWEEP_LOOP_EN
                        base_d  = del_start;
                        loop_d  = loop;
`endif
                    end
                end
                ST_ARM: begin
                    if (sedge) begin
                        cnt_d   = NW'(1);
                        state_d = ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (sedge) begin
                        if (cnt_q != navg_eff) begin
                            cnt_d = cnt_q + NW'(1);
                        end else if (!last_pt) begin
                            del_d = next_del[DW-1:0];
                            idx_d = idx_q + DW'(1);
                            upd_d = 1'b1;
                            cnt_d = NW'(1);
                        end else
`ifdef DELAY_SWEEP_LOOP_EN
                        if (loop_q) begin
                            del_d  = base_q;
                            idx_d  = '0;
                            upd_d  = 1'b1;
                            done_d = 1'b1;
                            cnt_d  = NW'(1);
                        end else
`endif
                        begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            del_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            stop_q  <= '0;
            navg_q  <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            del_q   <= del_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            stop_q  <= stop_d;
            navg_q  <= navg_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
        end
    end

`ifdef DELAY_SWEEP_LOOP_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_q <= '0;
            loop_q <= 1'b0;
        end else begin
            base_q <= base_d;
            loop_q <= loop_d;
        end
    end
`endif

    assign del_out   = del_q;
    assign pt_idx    = idx_q;
    assign upd       = upd_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Self-checking bench for delay_sweep_ctrl: directed corner sweeps plus random sweeps
// against a point-list model; the loop test runs when DELAY_SWEEP_LOOP_EN is defined.
module tb_delay_sweep_ctrl;
    import delay_sweep_pkg::*;

    localparam int DW = 16;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic          sync;
    logic [DW-1:0] del_start;
    logic [DW-1:0] del_step;
    logic [DW-1:0] del_stop;
    logic [NW-1:0] navg;
    logic [DW-1:0] del_out;
    logic          upd;
    logic          busy;
    logic          done;
    logic [DW-1:0] pt_idx;
    sweep_state_t  state_dbg;
`ifdef DELAY_SWEEP_LOOP_EN
    logic          loop;
`endif

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int n_eff;
    int pts_q[$];
    logic [DW-1:0] exp_q[$];

    delay_sweep_ctrl #(.DW(DW), .NW(NW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .sync      (sync),
`ifdef DELAY_SWEEP_LOOP_EN
        .loop      (loop),
`endif
        .del_start (del_start),
        .del_step  (del_step),
        .del_stop  (del_stop),
        .navg      (navg),
        .del_out   (del_out),
        .upd       (upd),
        .busy      (busy),
        .done      (done),
        .pt_idx    (pt_idx),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every upd strobe must present the next expected delay word.
    always @(negedge clk) begin
        if (resetn) begin
            if (done) done_cnt++;
            if (upd) begin
                if (exp_q.size() == 0)
                    check_eq("upd_unexpected", {16'h0, del_out}, 32'hFFFF_FFFF);
                else
                    check_eq("upd_value", {16'h0, del_out}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_pulse();
        sync = 1'b1;
        repeat (6) tick();
        sync = 1'b0;
        repeat (4) tick();
    endtask

    // Point list from the sweep rules: start, then keep adding step while the
    // sum fits in DW bits and does not pass the stop value.
    task automatic build_model(input int ds, input int st, input int sp, input int na);
        int v;
        pts_q.delete();
        n_eff = (na == 0) ? 1 : na;
        v = ds;
        forever begin
            pts_q.push_back(v);
            if (st == 0 || v + st > (1 << DW) - 1 || v + st > sp) break;
            v = v + st;
        end
    endtask

    task automatic begin_sweep(input int ds, input int st, input int sp, input int na);
        build_model(ds, st, sp, na);
        foreach (pts_q[i]) exp_q.push_back(DW'(pts_q[i]));
        del_start = DW'(ds);
        del_step  = DW'(st);
        del_stop  = DW'(sp);
        navg      = NW'(na);
        start = 1'b1;
        tick();
        start = 1'b0;
        del_start = DW'($urandom);
        del_step  = DW'($urandom);
        del_stop  = DW'($urandom);
        navg      = NW'($urandom);
`ifdef DELAY_SWEEP_LOOP_EN
        loop = ~loop;
`endif
        check_eq("start_busy", {31'h0, busy}, 32'd1);
        check_eq("start_del", {16'h0, del_out}, 32'(ds));
        check_eq("start_idx", {16'h0, pt_idx}, 32'd0);
        sync_pulse();
    endtask

    task automatic finish_sweep();
        int d0;
        int total;
        d0 = done_cnt;
        total = pts_q.size() * n_eff;
        for (int j = 1; j <= total; j++) begin
            sync_pulse();
            if (j < total) begin
                check_eq("dwell_busy", {31'h0, busy}, 32'd1);
                check_eq("dwell_del", {16'h0, del_out}, 32'(pts_q[j / n_eff]));
                check_eq("dwell_idx", {16'h0, pt_idx}, 32'(j / n_eff));
                check_eq("dwell_no_done", 32'(done_cnt), 32'(d0));
            end else begin
                check_eq("end_busy", {31'h0, busy}, 32'd0);
                check_eq("end_del", {16'h0, del_out}, 32'(pts_q[pts_q.size() - 1]));
                check_eq("end_idx", {16'h0, pt_idx}, 32'(pts_q.size() - 1));
                check_eq("end_done", 32'(done_cnt), 32'(d0 + 1));
                check_eq("end_upd_count", 32'(exp_q.size()), 32'd0);
            end
        end
    endtask

    task automatic run_sweep(input int ds, input int st, input int sp, input int na);
        begin_sweep(ds, st, sp, na);
        finish_sweep();
    endtask

    initial begin
        int d0;
        int ds, st, sp, na, mode;
        resetn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sync = 1'b0;
        del_start = '0;
        del_step = '0;
        del_stop = '0;
        navg = '0;
`ifdef DELAY_SWEEP_LOOP_EN
        loop = 1'b0;
`endif
        #2;
        check_eq("rst_del", {16'h0, del_out}, 32'd0);
        check_eq("rst_idx", {16'h0, pt_idx}, 32'd0);
        check_eq("rst_upd", {31'h0, upd}, 32'd0);
        check_eq("rst_done", {31'h0, done}, 32'd0);
        check_eq("rst_busy", {31'h0, busy}, 32'd0);
        check_eq("rst_state", {30'h0, state_dbg}, {30'h0, ST_IDLE});
        repeat (3) tick();
        resetn = 1'b1;
        repeat (2) tick();

        run_sweep(100, 50, 250, 2);
        run_sweep(300, 50, 200, 3);
        run_sweep(32'h20, 32'hFFF0, 32'hFFFF, 1);
        run_sweep(5, 7, 20, 0);
        run_sweep(40, 0, 500, 2);

        // Abort in the middle of the second point; a stray start is ignored first.
        d0 = done_cnt;
        begin_sweep(100, 50, 250, 2);
        sync_pulse();
        start = 1'b1;
        del_start = 16'd999;
        tick();
        start = 1'b0;
        sync_pulse();
        sync_pulse();
        check_eq("abort_pre_del", {16'h0, del_out}, 32'd150);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", {31'h0, busy}, 32'd0);
        check_eq("abort_del", {16'h0, del_out}, 32'd150);
        exp_q.delete();
        sync_pulse();
        sync_pulse();
        check_eq("abort_hold_del", {16'h0, del_out}, 32'd150);
        check_eq("abort_no_done", 32'(done_cnt), 32'(d0));

        // Asynchronous reset in DWELL, then a normal sweep.
        d0 = done_cnt;
        begin_sweep(100, 50, 250, 2);
        repeat (3) sync_pulse();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_del", {16'h0, del_out}, 32'd0);
        check_eq("mid_rst_idx", {16'h0, pt_idx}, 32'd0);
        check_eq("mid_rst_busy", {31'h0, busy}, 32'd0);
        check_eq("mid_rst_upd", {31'h0, upd}, 32'd0);
        check_eq("mid_rst_done", {31'h0, done}, 32'd0);
        tick();
        resetn = 1'b1;
        exp_q.delete();
        tick();
        check_eq("mid_rst_no_done", 32'(done_cnt), 32'(d0));
        run_sweep(200, 25, 260, 1);

        for (int k = 0; k < 10; k++) begin
            mode = $urandom_range(0, 5);
            na = $urandom_range(0, 3);
            if (mode == 0) begin
                sp = $urandom_range(0, 1000);
                ds = sp + $urandom_range(1, 1000);
                st = $urandom_range(1, 500);
            end else if (mode == 1) begin
                ds = $urandom_range(60000, 65535);
                st = $urandom_range(1000, 65535);
                sp = 65535;
            end else begin
                ds = $urandom_range(0, 1000);
                st = $urandom_range(100, 400);
                sp = ds + $urandom_range(0, 1200);
            end
            run_sweep(ds, st, sp, na);
        end

`ifdef DELAY_SWEEP_LOOP_EN
        loop = 1'b1;
        d0 = done_cnt;
        begin_sweep(10, 5, 15, 1);
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd15);
        exp_q.push_back(16'd10);
        for (int j = 1; j <= 4; j++) begin
            sync_pulse();
            check_eq("loop_busy", {31'h0, busy}, 32'd1);
            check_eq("loop_del", {16'h0, del_out}, (j % 2 == 1) ? 32'd15 : 32'd10);
            check_eq("loop_done", 32'(done_cnt), 32'(d0 + j / 2));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("loop_abort_busy", {31'h0, busy}, 32'd0);
        check_eq("loop_upd_count", 32'(exp_q.size()), 32'd0);
        loop = 1'b0;
        exp_q.delete();
`endif

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/delay_sweep_ctrl.md
DELAY_SWEEP_CTRL -- requirements
Module: delay_sweep_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, width of the delay word.
REQ-002 SHALL have parameter NW, default 8, width of the periods-per-point count.
REQ-003 SHALL have port clk  input  1  single system clock; all logic in this domain.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port abort  input  1  one-cycle request to stop the sweep.
REQ-007 SHALL have port sync  input  1  SYNC level from the pulse generator; a rising edge marks a period start; may be asynchronous to clk.
REQ-008 SHALL have port del_start  input  DW  first delay point.
REQ-009 SHALL have port del_step  input  DW  increment between points.
REQ-010 SHALL have port del_stop  input  DW  last allowed delay point, inclusive.
REQ-011 SHALL have port navg  input  NW  SYNC periods held at each point.
REQ-012 SHALL have port del_out  output  DW  delay word driven to the pulse generator.
REQ-013 SHALL have port upd  output  1  one-cycle strobe, high in the same cycle del_out takes a new value.
REQ-014 SHALL have port busy  output  1  high while the state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle strobe at sweep completion.
REQ-016 SHALL have port pt_idx  output  DW  zero-based index of the current point.

Function
REQ-017 SHALL pass sync through a 2-flop synchronizer followed by a rising-edge detector; the resulting internal pulse sedge SHALL occur 3 clk cycles after the sync rise.
REQ-018 SHALL implement states IDLE, ARM, DWELL, DONE.
REQ-019 IDLE: on start, SHALL capture del_start/step/stop/navg into shadow registers, set del_out=del_start, pt_idx=0, upd=1, and go to ARM; later input changes SHALL be ignored until the next start.
REQ-020 ARM: on sedge, SHALL clear the period counter to 1 and go to DWELL; this SHALL discard the partial period in progress at start.
REQ-021 DWELL: each sedge SHALL increment the period counter; the sedge on which the counter equals navg SHALL end the point.
REQ-022 At end of point, SHALL compute next = del_out + del_step at DW+1 bits; if del_step==0, the carry bit is set, or next > del_stop, SHALL go to DONE, else SHALL set del_out=next, increment pt_idx, pulse upd, and clear the counter to 1 in that same cycle (no extra ARM).
REQ-023 navg==0 SHALL be treated as navg==1.
REQ-024 del_start > del_stop SHALL yield a single point at del_start.
REQ-025 DONE: SHALL assert done for exactly one cycle, then go to IDLE; del_out SHALL hold its last value.
REQ-026 abort SHALL have priority over start and sedge; from any non-IDLE state it SHALL go to IDLE on the next edge, hold del_out, and not pulse done or upd.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 On resetn low, SHALL asynchronously force state=IDLE, del_out=0, pt_idx=0, the counter to 0, upd=0, done=0, busy=0, and clear the synchronizer flops; reset mid-sweep SHALL abandon the sweep with no done pulse.

Configuration
REQ-029 With macro DELAY_SWEEP_LOOP_EN defined, SHALL add input loop (1 bit, sampled at start); when loop=1, completion SHALL pulse done, reload del_out=del_start, set pt_idx=0, pulse upd, and continue in DWELL until abort.
REQ-030 Without DELAY_SWEEP_LOOP_EN, the loop port SHALL be absent and behaviour SHALL be as in REQ-025.

Structure
REQ-031 Package delay_sweep_pkg SHALL hold the state enum type and the DW/NW default constants.
REQ-032 The synchronizer and edge detector SHALL be one sub-module, sync_edge_det.

Verification
REQ-033 del_start=100, step=50, stop=250, navg=2, start -> del_out 100,150,200,250; upd 4 times; done after the 8th counted sedge; pt_idx ends at 3.
REQ-034 del_start=300, stop=200 -> single point 300 held for navg periods, then done; upd once.
REQ-035 step=0xFFF0, start=0x0020, stop=0xFFFF -> carry detected after the first point; done; del_out stays 0x0020.
REQ-036 abort during the 2nd point of the REQ-033 sweep -> busy low next cycle; del_out=150; no done.
REQ-037 resetn low mid-DWELL -> all outputs 0 immediately; a subsequent start sweeps normally.
REQ-038 Under DELAY_SWEEP_LOOP_EN, loop=1, 2 points, navg=1 -> done every 2 sedges; del_out alternates between the two points until abort.
